// File: rtl/data_mem_arbiter.sv
// Two-port (CPU A, loader/debug B) arbiter onto one single-cycle data memory port.
// Defining DATA_MEM_ARB_ROUND_ROBIN_EN replaces fixed A-priority tie breaking with round robin.
module data_mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [3:0]  a_wren,
    input  logic        b_req,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [3:0]  b_wren,
    input  logic        b_lock,
    output logic        a_ack,
    output logic        b_ack,
    output logic [31:0] a_rdata,
    output logic [31:0] b_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wren,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    // lock_cnt holds the number of completed OWN_B cycles, so 7 marks the 8th one
    localparam logic [3:0] LOCK_LAST = 4'd7;
    localparam logic [3:0] CNT_MAX   = 4'd15;

    state_t     state;
    state_t     next_state;
    logic [3:0] lock_cnt;
    logic       lock_expired;
    logic       lock_hold;
    logic       tie_to_b;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt <= 4'd0;
        end else if (state != OWN_B) begin
            lock_cnt <= 4'd0;
        end else if (lock_cnt != CNT_MAX) begin
            lock_cnt <= lock_cnt + 4'd1;
        end
    end

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    logic last_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b <= 1'b1;
        end else if (state == OWN_A) begin
            last_b <= 1'b0;
        end else if (state == OWN_B) begin
            last_b <= 1'b1;
        end
    end

    // The ack being issued this cycle is the most recent grant, ahead of last_b.
    assign tie_to_b = (state == OWN_A) || ((state == IDLE) && !last_b);
`else
    assign tie_to_b = 1'b0;
`endif

    assign lock_expired = (state == OWN_B) && (lock_cnt >= LOCK_LAST);
    assign lock_hold    = b_req && b_lock && !lock_expired;

    always_comb begin
        next_state = IDLE;
        if (a_req && b_req) begin
            next_state = (lock_hold || tie_to_b) ? OWN_B : OWN_A;
        end else if (a_req) begin
            next_state = OWN_A;
        end else if (b_req) begin
            next_state = OWN_B;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wren  = 4'b0000;
        a_ack     = 1'b0;
        b_ack     = 1'b0;
        a_rdata   = 32'd0;
        b_rdata   = 32'd0;
        owner     = state;
        case (state)
            OWN_A: begin
                mem_addr  = a_addr;
                mem_wdata = a_wdata;
                mem_wren  = a_wren;
                a_ack     = 1'b1;
                a_rdata   = mem_rdata;
            end
            OWN_B: begin
                mem_addr  = b_addr;
                mem_wdata = b_wdata;
                mem_wren  = b_wren;
                b_ack     = 1'b1;
                b_rdata   = mem_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: vector table plus lock and reset sequences,
// with a behavioural byte-lane memory on the mem_* port.
module tb_data_mem_arbiter;

    typedef struct {
        logic [1:0]  owner;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wren;
        logic [31:0] a_rdata;
        logic [31:0] b_rdata;
    } exp_t;

    typedef struct {
        logic        a_req;
        logic [31:0] a_addr;
        logic [31:0] a_wdata;
        logic [3:0]  a_wren;
        logic        b_req;
        logic [31:0] b_addr;
        logic [31:0] b_wdata;
        logic [3:0]  b_wren;
        logic        b_lock;
        exp_t        ex;
    } vec_t;

    localparam logic [1:0] O_IDLE = 2'b00;
    localparam logic [1:0] O_A    = 2'b01;
    localparam logic [1:0] O_B    = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, b_req, b_lock;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [3:0]  a_wren, b_wren;
    logic        a_ack, b_ack;
    logic [31:0] a_rdata, b_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wren;
    logic [1:0]  owner;

    logic        mem_clear;
    logic [31:0] mem [0:63];
    logic [31:0] model_mem [0:63];
    exp_t        sb_q[$];
    vec_t        vecs [12];
    int          checks = 0;
    int          failures = 0;

    data_mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_wren    (a_wren),
        .b_req     (b_req),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_wren    (b_wren),
        .b_lock    (b_lock),
        .a_ack     (a_ack),
        .b_ack     (b_ack),
        .a_rdata   (a_rdata),
        .b_rdata   (b_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
            mem[4] <= 32'hDEAD_BEEF;
            mem[5] <= 32'h5555_AAAA;
        end else begin
            for (int i = 0; i < 4; i++)
                if (mem_wren[i]) mem[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mk(
        input logic ar, input logic [31:0] aa, input logic [31:0] ad, input logic [3:0] aw,
        input logic br, input logic [31:0] ba, input logic [31:0] bd, input logic [3:0] bw,
        input logic bl, input logic [1:0] own, input logic [31:0] maddr, input logic [31:0] mwd,
        input logic [3:0] mw, input logic [31:0] ard, input logic [31:0] brd);
        vec_t v;
        v.a_req = ar;  v.a_addr = aa;  v.a_wdata = ad;  v.a_wren = aw;
        v.b_req = br;  v.b_addr = ba;  v.b_wdata = bd;  v.b_wren = bw;  v.b_lock = bl;
        v.ex.owner = own;     v.ex.mem_addr = maddr;  v.ex.mem_wdata = mwd;
        v.ex.mem_wren = mw;   v.ex.a_rdata = ard;     v.ex.b_rdata = brd;
        return v;
    endfunction

    // Drive one cycle's inputs just after the edge, check that cycle's outputs at the falling edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        a_req = v.a_req;  a_addr = v.a_addr;  a_wdata = v.a_wdata;  a_wren = v.a_wren;
        b_req = v.b_req;  b_addr = v.b_addr;  b_wdata = v.b_wdata;  b_wren = v.b_wren;
        b_lock = v.b_lock;
        sb_q.push_back(v.ex);
        @(negedge clk);
        e = sb_q.pop_front();
        check({tag, " owner"},     32'(owner),    32'(e.owner));
        check({tag, " a_ack"},     32'(a_ack),    32'(e.owner == O_A));
        check({tag, " b_ack"},     32'(b_ack),    32'(e.owner == O_B));
        check({tag, " mem_addr"},  mem_addr,      e.mem_addr);
        check({tag, " mem_wdata"}, mem_wdata,     e.mem_wdata);
        check({tag, " mem_wren"},  32'(mem_wren), 32'(e.mem_wren));
        check({tag, " a_rdata"},   a_rdata,       e.a_rdata);
        check({tag, " b_rdata"},   b_rdata,       e.b_rdata);
        if (e.mem_wren == 4'hF) model_mem[e.mem_addr[7:2]] = e.mem_wdata;
    endtask

    initial begin
        rst = 1'b1;  mem_clear = 1'b1;
        a_req = 1'b0;  a_addr = '0;  a_wdata = '0;  a_wren = '0;
        b_req = 1'b0;  b_addr = '0;  b_wdata = '0;  b_wren = '0;  b_lock = 1'b0;
        for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;
        model_mem[4] = 32'hDEAD_BEEF;
        model_mem[5] = 32'h5555_AAAA;

        // Both read for 4 cycles, single A read, then A back-to-back writes.
        vecs[0]  = mk(0, 0, 0, 0,           0, 0, 0, 0, 0,  O_IDLE, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 32'h10, 0, 0,      1, 32'h14, 0, 0, 0,  O_IDLE, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 32'h10, 0, 0,      1, 32'h14, 0, 0, 0,  O_A, 32'h10, 0, 0, 32'hDEAD_BEEF, 0);
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
        vecs[3]  = mk(1, 32'h10, 0, 0,      1, 32'h14, 0, 0, 0,  O_B, 32'h14, 0, 0, 0, 32'h5555_AAAA);
        vecs[4]  = mk(1, 32'h10, 0, 0,      1, 32'h14, 0, 0, 0,  O_A, 32'h10, 0, 0, 32'hDEAD_BEEF, 0);
        vecs[5]  = mk(0, 32'h10, 0, 0,      0, 32'h14, 0, 0, 0,  O_B, 32'h14, 0, 0, 0, 32'h5555_AAAA);
`else
        vecs[3]  = mk(1, 32'h10, 0, 0,      1, 32'h14, 0, 0, 0,  O_A, 32'h10, 0, 0, 32'hDEAD_BEEF, 0);
        vecs[4]  = mk(1, 32'h10, 0, 0,      1, 32'h14, 0, 0, 0,  O_A, 32'h10, 0, 0, 32'hDEAD_BEEF, 0);
        vecs[5]  = mk(0, 32'h10, 0, 0,      0, 32'h14, 0, 0, 0,  O_A, 32'h10, 0, 0, 32'hDEAD_BEEF, 0);
`endif
        vecs[6]  = mk(1, 32'h10, 0, 0,      0, 0, 0, 0, 0,  O_IDLE, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 32'h10, 0, 0,      0, 0, 0, 0, 0,  O_A, 32'h10, 0, 0, 32'hDEAD_BEEF, 0);
        vecs[8]  = mk(1, 32'h4, 32'h1, 4'hF, 0, 0, 0, 0, 0,  O_IDLE, 0, 0, 0, 0, 0);
        vecs[9]  = mk(1, 32'h4, 32'h1, 4'hF, 0, 0, 0, 0, 0,  O_A, 32'h4, 32'h1, 4'hF, 0, 0);
        vecs[10] = mk(0, 32'h8, 32'h2, 4'hF, 0, 0, 0, 0, 0,  O_A, 32'h8, 32'h2, 4'hF, 0, 0);
        vecs[11] = mk(0, 0, 0, 0,           0, 0, 0, 0, 0,  O_IDLE, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset owner",     32'(owner),    32'd0);
        check("reset a_ack",     32'(a_ack),    32'd0);
        check("reset b_ack",     32'(b_ack),    32'd0);
        check("reset mem_wren",  32'(mem_wren), 32'd0);
        check("reset mem_addr",  mem_addr,      32'd0);
        check("reset mem_wdata", mem_wdata,     32'd0);
        rst = 1'b0;
        mem_clear = 1'b0;

        for (int k = 0; k < 12; k++) apply(vecs[k], $sformatf("vec%0d", k));
        check("b2b mem[0x4]", mem[1], 32'h1);
        check("b2b mem[0x8]", mem[2], 32'h2);

        // Locked B burst over 0x0..0x1C with A waiting from the first B ack onward.
        apply(mk(0, 0, 0, 0, 1, 32'h0, 32'hB000_0000, 4'hF, 1, O_IDLE, 0, 0, 0, 0, 0), "lock0");
        for (int i = 1; i <= 8; i++) begin
            apply(mk(1, 32'h10, 0, 0, 1, 32'(4 * (i - 1)), 32'hB000_0000 + 32'(i - 1), 4'hF, 1,
                     O_B, 32'(4 * (i - 1)), 32'hB000_0000 + 32'(i - 1), 4'hF, 0, model_mem[i - 1]),
                  $sformatf("lock%0d", i));
        end
        apply(mk(0, 32'h10, 0, 0, 0, 0, 0, 0, 0, O_A, 32'h10, 0, 0, model_mem[4], 0), "lock9");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0, 0, 0, 0), "lock10");

        // Reset pulse in the middle of a B write cycle.
        apply(mk(0, 0, 0, 0, 1, 32'h20, 32'hCAFE_F00D, 4'hF, 0, O_IDLE, 0, 0, 0, 0, 0), "rst0");
        @(posedge clk);
        #1;
        check("pre-rst owner", 32'(owner), 32'(O_B));
        check("pre-rst b_ack", 32'(b_ack), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("in-rst owner",     32'(owner),    32'd0);
        check("in-rst b_ack",     32'(b_ack),    32'd0);
        check("in-rst mem_wren",  32'(mem_wren), 32'd0);
        check("in-rst mem_addr",  mem_addr,      32'd0);
        check("in-rst mem_wdata", mem_wdata,     32'd0);
        b_req = 1'b0;  b_addr = '0;  b_wdata = '0;  b_wren = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0, 0, 0, 0), "post-rst0");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0, 0, 0, 0), "post-rst1");

        for (int i = 0; i < 10; i++) check($sformatf("mem word %0d", i), mem[i], model_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
